// File: rtl/stun_pkg.sv
// Shared types and the square blast-radius test for the stun manager.
package stun_pkg;

  typedef enum logic [1:0] {IDLE, STUNNED, IMMUNE} stun_state_e;

  localparam int unsigned COORD_W_DEFAULT = 6;
  typedef logic [COORD_W_DEFAULT-1:0] coord_t;

  // Coordinates arrive zero-extended into int, so edge cells never alias across the grid.
  function automatic logic in_blast(input int px, input int py, input int bx, input int by,
                                    input int r);
    int dx;
    int dy;
    dx = px - bx;
    dy = py - by;
    return (dx <= r) && (dx >= -r) && (dy <= r) && (dy >= -r);
  endfunction

endpackage

// File: rtl/stun_channel.sv
// One player's stun timer: hit test, stunned/immune/idle FSM and seconds countdown.
module stun_channel
  import stun_pkg::*;
#(
  parameter int unsigned COORD_W       = 6,
  parameter int unsigned BLAST_R       = 1,
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned STUN_SECS     = 5,
  parameter int unsigned IMMUNE_CYCLES = 25000000,
  parameter int unsigned RETRIGGER     = 0,
  parameter int unsigned SW            = $clog2(STUN_SECS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bomb_valid,
  input  logic [COORD_W-1:0] bomb_x,
  input  logic [COORD_W-1:0] bomb_y,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               stun_en,
  output logic               immune,
  output logic               stun_hit,
  output logic [SW-1:0]      secs_left
);

  localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned IMM_W = (IMMUNE_CYCLES > 1) ? $clog2(IMMUNE_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [IMM_W-1:0] IMM_RELOAD = IMM_W'((IMMUNE_CYCLES == 0) ? 0 : IMMUNE_CYCLES - 1);

  stun_state_e      state;
  logic [SUB_W-1:0] sub;
  logic [IMM_W-1:0] imm;
  logic             hit;

  assign hit = bomb_valid &&
               in_blast(int'(px), int'(py), int'(bomb_x), int'(bomb_y), int'(BLAST_R));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sub       <= '0;
      imm       <= '0;
      secs_left <= '0;
      stun_en   <= 1'b0;
      immune    <= 1'b0;
      stun_hit  <= 1'b0;
    end else begin
      stun_hit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            state     <= STUNNED;
            secs_left <= SW'(STUN_SECS);
            sub       <= SUB_RELOAD;
            stun_en   <= 1'b1;
            stun_hit  <= 1'b1;
          end
        end
        STUNNED: begin
          // A retrigger wins over expiry landing in the same cycle.
          if ((RETRIGGER != 0) && hit) begin
            secs_left <= SW'(STUN_SECS);
            sub       <= SUB_RELOAD;
            stun_hit  <= 1'b1;
          end else if (sub != '0) begin
            sub <= sub - SUB_W'(1);
          end else begin
            sub <= SUB_RELOAD;
            if (secs_left == SW'(1)) begin
              secs_left <= '0;
              stun_en   <= 1'b0;
              if (IMMUNE_CYCLES == 0) begin
                state <= IDLE;
              end else begin
                state  <= IMMUNE;
                immune <= 1'b1;
                imm    <= IMM_RELOAD;
              end
            end else begin
              secs_left <= secs_left - SW'(1);
            end
          end
        end
        IMMUNE: begin
          if (imm != '0) begin
            imm <= imm - IMM_W'(1);
          end else begin
            state  <= IDLE;
            immune <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          stun_en <= 1'b0;
          immune  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stun_manager.sv
// Blast-to-stun front end: one independent stun channel per player, with bomb-owner exemption.
module stun_manager
  import stun_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned COORD_W       = 6,
  parameter int unsigned BLAST_R       = 1,
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned STUN_SECS     = 5,
  parameter int unsigned IMMUNE_CYCLES = 25000000,
  parameter int unsigned RETRIGGER     = 0,
  parameter int unsigned FRIENDLY_FIRE = 1,
  parameter int unsigned OWN_W         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  parameter int unsigned SW            = $clog2(STUN_SECS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bomb_valid,
  input  logic [COORD_W-1:0]             bomb_x,
  input  logic [COORD_W-1:0]             bomb_y,
  input  logic [OWN_W-1:0]               bomb_owner,
  input  logic [NUM_PLAYERS*COORD_W-1:0] player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] player_y,
  output logic [NUM_PLAYERS-1:0]         stun_en,
  output logic [NUM_PLAYERS-1:0]         immune,
  output logic [NUM_PLAYERS-1:0]         stun_hit,
  output logic [NUM_PLAYERS*SW-1:0]      secs_left
);

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    logic ch_valid;

    assign ch_valid = bomb_valid && !((FRIENDLY_FIRE == 0) && (int'(bomb_owner) == i));

    stun_channel #(
      .COORD_W      (COORD_W),
      .BLAST_R      (BLAST_R),
      .TICKS_PER_SEC(TICKS_PER_SEC),
      .STUN_SECS    (STUN_SECS),
      .IMMUNE_CYCLES(IMMUNE_CYCLES),
      .RETRIGGER    (RETRIGGER),
      .SW           (SW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .bomb_valid(ch_valid),
      .bomb_x    (bomb_x),
      .bomb_y    (bomb_y),
      .px        (player_x[i*COORD_W +: COORD_W]),
      .py        (player_y[i*COORD_W +: COORD_W]),
      .stun_en   (stun_en[i]),
      .immune    (immune[i]),
      .stun_hit  (stun_hit[i]),
      .secs_left (secs_left[i*SW +: SW])
    );
  end

endmodule

// File: tb/tb_stun_manager.sv
// Bench for stun_manager: two instances (no retrigger / friendly fire, retrigger / owner exempt)
// share stimulus and are checked every cycle against a stun-window model.
module tb_stun_manager;

  localparam int NP  = 2;
  localparam int CW  = 6;
  localparam int TPS = 4;
  localparam int SS  = 3;
  localparam int IC  = 5;
  localparam int SW  = 2;
  localparam int STUN_LEN = SS * TPS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset      = 1'b1;
  logic             bomb_valid = 1'b0;
  logic [CW-1:0]    bomb_x     = '0;
  logic [CW-1:0]    bomb_y     = '0;
  logic             bomb_owner = 1'b0;
  logic [NP*CW-1:0] player_x   = '0;
  logic [NP*CW-1:0] player_y   = '0;

  logic [NP-1:0]    en_a, im_a, hit_a, en_b, im_b, hit_b;
  logic [NP*SW-1:0] secs_a, secs_b;

  stun_manager #(
    .NUM_PLAYERS(NP), .COORD_W(CW), .BLAST_R(1), .TICKS_PER_SEC(TPS), .STUN_SECS(SS),
    .IMMUNE_CYCLES(IC), .RETRIGGER(0), .FRIENDLY_FIRE(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bomb_valid(bomb_valid), .bomb_x(bomb_x), .bomb_y(bomb_y),
    .bomb_owner(bomb_owner), .player_x(player_x), .player_y(player_y),
    .stun_en(en_a), .immune(im_a), .stun_hit(hit_a), .secs_left(secs_a)
  );

  stun_manager #(
    .NUM_PLAYERS(NP), .COORD_W(CW), .BLAST_R(1), .TICKS_PER_SEC(TPS), .STUN_SECS(SS),
    .IMMUNE_CYCLES(IC), .RETRIGGER(1), .FRIENDLY_FIRE(0)
  ) dut_b (
    .clk(clk), .reset(reset), .bomb_valid(bomb_valid), .bomb_x(bomb_x), .bomb_y(bomb_y),
    .bomb_owner(bomb_owner), .player_x(player_x), .player_y(player_y),
    .stun_en(en_b), .immune(im_b), .stun_hit(hit_b), .secs_left(secs_b)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rt[2]   = '{0, 1};
  int ff[2]   = '{1, 0};

  // Model: each channel remembers the first cycle of its latest stun; everything else follows.
  bit active[2][NP];
  int s_cyc[2][NP];

  function automatic bit m_stunned(int d, int p, int c);
    return active[d][p] && c >= s_cyc[d][p] && c < s_cyc[d][p] + STUN_LEN;
  endfunction

  function automatic bit m_immune(int d, int p, int c);
    return active[d][p] && c >= s_cyc[d][p] + STUN_LEN && c < s_cyc[d][p] + STUN_LEN + IC;
  endfunction

  function automatic int m_secs(int d, int p, int c);
    return m_stunned(d, p, c) ? SS - (c - s_cyc[d][p]) / TPS : 0;
  endfunction

  function automatic bit m_in_blast(int p);
    int dx;
    int dy;
    dx = int'(player_x[p*CW +: CW]) - int'(bomb_x);
    dy = int'(player_y[p*CW +: CW]) - int'(bomb_y);
    return (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        if (reset) begin
          active[d][p] = 1'b0;
        end else if (bomb_valid && m_in_blast(p) && !(ff[d] == 0 && p == int'(bomb_owner))) begin
          if ((!m_stunned(d, p, cyc) && !m_immune(d, p, cyc)) ||
              (rt[d] != 0 && m_stunned(d, p, cyc))) begin
            active[d][p] = 1'b1;
            s_cyc[d][p]  = cyc + 1;
          end
        end
      end
    end
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        int a_en, a_im, a_hit, a_secs;
        a_en   = (d == 0) ? int'(en_a[p])  : int'(en_b[p]);
        a_im   = (d == 0) ? int'(im_a[p])  : int'(im_b[p]);
        a_hit  = (d == 0) ? int'(hit_a[p]) : int'(hit_b[p]);
        a_secs = (d == 0) ? int'(secs_a[p*SW +: SW]) : int'(secs_b[p*SW +: SW]);
        check($sformatf("dut%0d.stun_en[%0d]", d, p), a_en,
              reset ? 0 : int'(m_stunned(d, p, cyc)));
        check($sformatf("dut%0d.immune[%0d]", d, p), a_im,
              reset ? 0 : int'(m_immune(d, p, cyc)));
        check($sformatf("dut%0d.stun_hit[%0d]", d, p), a_hit,
              reset ? 0 : int'(active[d][p] && s_cyc[d][p] == cyc));
        check($sformatf("dut%0d.secs_left[%0d]", d, p), a_secs,
              reset ? 0 : m_secs(d, p, cyc));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_players(input int x0, input int y0, input int x1, input int y1);
    player_x = {CW'(x1), CW'(x0)};
    player_y = {CW'(y1), CW'(y0)};
  endtask

  // Pulses bomb_valid for one cycle; returns one cycle after the bomb cycle.
  task automatic fire(input int bx, input int by, input int own);
    bomb_x     = CW'(bx);
    bomb_y     = CW'(by);
    bomb_owner = own[0];
    bomb_valid = 1'b1;
    step(1);
    bomb_valid = 1'b0;
  endtask

  initial begin
    step(3);
    check("reset_stun_en", int'(en_a), 0);
    check("reset_secs", int'(secs_a), 0);
    reset = 1'b0;
    step(2);

    // Basic stun of P0 only; full stunned/immune/idle timeline.
    set_players(11, 9, 13, 10);
    fire(10, 10, 1);
    check("t1_stun_en_c1", int'(en_a), 1);
    check("t1_stun_hit_c1", int'(hit_a), 1);
    check("t1_secs_c1", int'(secs_a[1:0]), 3);
    step(4);
    check("t1_secs_c5", int'(secs_a[1:0]), 2);
    step(7);
    check("t1_stun_en_c12", int'(en_a), 1);
    check("t1_secs_c12", int'(secs_a[1:0]), 1);
    step(1);
    check("t1_stun_en_c13", int'(en_a), 0);
    check("t1_immune_c13", int'(im_a), 1);
    step(4);
    check("t1_immune_c17", int'(im_a), 1);
    step(1);
    check("t1_immune_c18", int'(im_a), 0);
    step(5);

    // Grid corner: no wraparound hit on the far corner.
    set_players(63, 63, 0, 1);
    fire(0, 0, 0);
    check("t2_stun_en_a", int'(en_a), 2);
    check("t2_stun_en_b", int'(en_b), 2);
    step(20);

    // Second bomb at cycle 6: ignored without retrigger, reloads with it.
    set_players(11, 9, 13, 10);
    fire(10, 10, 1);
    step(5);
    fire(10, 10, 1);
    check("t3_rehit_b", int'(hit_b), 1);
    check("t3_rehit_a", int'(hit_a), 0);
    check("t3_secs_b", int'(secs_b[1:0]), 3);
    step(5);
    check("t3_en_a_c12", int'(en_a), 1);
    step(1);
    check("t3_en_a_c13", int'(en_a), 0);
    check("t3_en_b_c13", int'(en_b), 1);
    step(5);
    check("t3_en_b_c18", int'(en_b), 1);
    step(1);
    check("t3_en_b_c19", int'(en_b), 0);
    step(20);

    // Hits during immunity (including its last cycle) are dropped; after it they stun.
    fire(10, 10, 1);
    step(13);
    fire(10, 10, 1);
    check("t4_imm_hit_en", int'(en_a), 0);
    check("t4_imm_hit_im", int'(im_a), 1);
    step(2);
    fire(10, 10, 1);
    check("t4_last_imm_en", int'(en_a), 0);
    check("t4_last_imm_im", int'(im_a), 0);
    step(1);
    fire(10, 10, 1);
    check("t4_restun_en", int'(en_a), 1);
    check("t4_restun_hit", int'(hit_a), 1);
    step(20);

    // Owner exemption: owner 0, both players inside the blast.
    set_players(20, 21, 21, 19);
    fire(20, 20, 0);
    check("t5_ff_on", int'(en_a), 3);
    check("t5_ff_off", int'(en_b), 2);
    step(20);

    // Asynchronous reset mid-stun.
    set_players(11, 9, 13, 10);
    fire(10, 10, 1);
    step(4);
    reset = 1'b1;
    #1;
    check("t6_rst_en_a", int'(en_a), 0);
    check("t6_rst_en_b", int'(en_b), 0);
    check("t6_rst_secs", int'(secs_a), 0);
    step(2);
    reset = 1'b0;
    step(15);
    check("t6_quiet_en", int'(en_a), 0);
    check("t6_quiet_im", int'(im_a), 0);
    check("t6_quiet_hit", int'(hit_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
